// File: rtl/axi3_sram_responder_if.sv
// axi3_sram_responder_if: AXI3 32-bit bus between a master and the SRAM responder
interface axi3_sram_responder_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );
endinterface

// File: rtl/axi3_sram_responder.sv
// axi3_sram_responder: single-transaction AXI3 slave over a byte-writable word SRAM
module axi3_sram_responder #(
   parameter int MEM_AW = 12
) (
   input logic                  aclk,
   input logic                  aresetn,
   axi3_sram_responder_if.slave s
);
   typedef enum logic [2:0] {IDLE, RD_FETCH, RD_BEAT, WR_DATA, WR_RESP} state_t;
   state_t              state, state_n;
   logic                prio;
   logic [3:0]          id, len, beat;
   logic [2:0]          size;
   logic [1:0]          burst;
   logic [31:0]         addr, nxt, inc, mask, rd_word;
   logic                err, oor, last, w_beat, r_adv;
   logic [MEM_AW-1:0]   idx;
   logic [31:0]         mem [2**MEM_AW];
   logic                unused;
   assign unused = ^{s.arlock, s.arcache, s.arprot, s.awlock, s.awcache, s.awprot, s.wid};
   assign inc    = 32'd1 << size;
   assign mask   = (({28'd0, len} + 32'd1) << size) - 32'd1;
   assign nxt    = burst == 2'b00 ? addr :
                   burst == 2'b10 ? (addr & ~mask) | ((addr + inc) & mask) : addr + inc;
   assign idx    = addr[MEM_AW+1:2];
   assign oor    = |(addr >> (MEM_AW + 2));
   assign last   = beat == len;
   assign w_beat = state == WR_DATA && s.wvalid;
   assign r_adv  = state == RD_BEAT && s.rready && !last;
   assign s.rid   = id;
   assign s.bid   = id;
   assign s.rdata = oor ? 32'd0 : rd_word;
   assign s.rresp = {oor || &burst, 1'b0};
   assign s.rlast = state == RD_BEAT && last;
   assign s.bresp = {err, 1'b0};
   always_ff @(posedge aclk)
      state <= !aresetn ? IDLE : state_n;
   always_comb begin
      state_n   = state;
      s.arready = 1'b0;
      s.awready = 1'b0;
      s.wready  = 1'b0;
      s.rvalid  = 1'b0;
      s.bvalid  = 1'b0;
      case (state)
         IDLE: begin
            s.arready = s.arvalid && (!s.awvalid || !prio);
            s.awready = s.awvalid && (!s.arvalid || prio);
            state_n   = s.arready ? RD_FETCH : s.awready ? WR_DATA : IDLE;
         end
         RD_FETCH: state_n = RD_BEAT;
         RD_BEAT: begin
            s.rvalid = 1'b1;
            state_n  = !s.rready ? RD_BEAT : last ? IDLE : RD_FETCH;
         end
         WR_DATA: begin
            s.wready = 1'b1;
            state_n  = s.wvalid && last ? WR_RESP : WR_DATA;
         end
         WR_RESP: begin
            s.bvalid = 1'b1;
            state_n  = s.bready ? IDLE : WR_RESP;
         end
         default: state_n = IDLE;
      endcase
   end
   // prio=1 favours the write channel; it toggles to the side not just granted
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         prio  <= 1'b0;
         id    <= '0;
         addr  <= '0;
         len   <= '0;
         size  <= '0;
         burst <= '0;
         beat  <= '0;
         err   <= 1'b0;
      end else if (s.arready || s.awready) begin
         prio  <= s.arready;
         id    <= s.arready ? s.arid : s.awid;
         addr  <= s.arready ? s.araddr : s.awaddr;
         len   <= s.arready ? s.arlen : s.awlen;
         size  <= s.arready ? s.arsize : s.awsize;
         burst <= s.arready ? s.arburst : s.awburst;
         beat  <= '0;
         err   <= !s.arready && &s.awburst;
      end else if (w_beat || r_adv) begin
         addr  <= nxt;
         beat  <= beat + 4'd1;
         err   <= err | (w_beat & (oor | (s.wlast != last)));
      end
   end
   always_ff @(posedge aclk)
      rd_word <= !aresetn ? 32'd0 : state == RD_FETCH ? mem[idx] : rd_word;
   always_ff @(posedge aclk)
      if (aresetn && w_beat && !oor)
         for (int i = 0; i < 4; i++)
            if (s.wstrb[i]) mem[idx][8*i +: 8] <= s.wdata[8*i +: 8];
endmodule

// File: tb/tb_axi3_sram_responder.sv
// tb_axi3_sram_responder: directed AXI3 sequences against hand-computed responses
module tb_axi3_sram_responder;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;
   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;
   int vectors = 0;
   int miscompares = 0;
   int t, f, u, v, bt;
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] re [16];
   axi3_sram_responder_if bus();
   axi3_sram_responder #(.MEM_AW(12)) dut (.aclk(aclk), .aresetn(aresetn), .s(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_ar(input logic [31:0] a, input logic [3:0] l, input logic [2:0] sz,
                         input logic [1:0] b, input logic [3:0] i);
      bus.araddr = a; bus.arlen = l; bus.arsize = sz; bus.arburst = b; bus.arid = i;
      bus.arvalid = 1'b1;
   endtask

   task automatic set_aw(input logic [31:0] a, input logic [3:0] l, input logic [2:0] sz,
                         input logic [1:0] b, input logic [3:0] i);
      bus.awaddr = a; bus.awlen = l; bus.awsize = sz; bus.awburst = b; bus.awid = i;
      bus.wid = i; bus.awvalid = 1'b1;
   endtask

   task automatic wait_ar(output int hs);
      bit ok = 0;
      hs = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         if (bus.arready) begin ok = 1; hs = cyc; end
         @(negedge aclk);
      end
      bus.arvalid = 1'b0;
      chk("ar_handshake", ok, 1);
   endtask

   task automatic wait_aw(output int hs);
      bit ok = 0;
      hs = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         if (bus.awready) begin ok = 1; hs = cyc; end
         @(negedge aclk);
      end
      bus.awvalid = 1'b0;
      chk("aw_handshake", ok, 1);
   endtask

   task automatic read_data(input int n, input logic [3:0] id, input logic [1:0] resp,
                            input int stall, input bit cd, output int first, output int lhs);
      bit ok;
      int hs = 0;
      first = 0;
      lhs = 0;
      for (int b = 0; b < n; b++) begin
         ok = 0;
         for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (bus.rvalid) ok = 1; else @(negedge aclk);
         end
         chk("r_valid", ok, 1);
         if (b == 0) first = cyc;
         else chk("r_beat_gap", cyc, hs + 2);
         if (b == 0)
            for (int s = 0; s < stall; s++) begin
               chk("stall_rvalid", bus.rvalid, 1);
               chk("stall_rdata", bus.rdata, re[0]);
               chk("stall_rlast", bus.rlast, n == 1);
               @(negedge aclk);
               #1;
            end
         if (cd) chk("r_data", bus.rdata, re[b]);
         chk("r_id", bus.rid, id);
         chk("r_resp", bus.rresp, resp);
         chk("r_last", bus.rlast, b == n - 1);
         hs = cyc;
         bus.rready = 1'b1;
         @(negedge aclk);
         bus.rready = 1'b0;
      end
      lhs = hs;
   endtask

   task automatic write_data(input int n, input int wl, output int first, output int lhs);
      bit ok;
      first = 0;
      lhs = 0;
      for (int b = 0; b < n; b++) begin
         bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == wl);
         ok = 0;
         for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (bus.wready) ok = 1; else @(negedge aclk);
         end
         chk("w_ready", ok, 1);
         if (b == 0) first = cyc;
         else chk("w_back_to_back", cyc, lhs + 1);
         lhs = cyc;
         @(negedge aclk);
      end
      bus.wvalid = 1'b0;
      bus.wlast = 1'b0;
   endtask

   task automatic b_resp(input logic [3:0] id, input logic [1:0] resp, output int hs);
      bit ok = 0;
      hs = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         if (bus.bvalid) begin ok = 1; hs = cyc; end else @(negedge aclk);
      end
      chk("b_valid", ok, 1);
      chk("b_id", bus.bid, id);
      chk("b_resp", bus.bresp, resp);
      bus.bready = 1'b1;
      @(negedge aclk);
      bus.bready = 1'b0;
   endtask

   initial begin
      bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
      bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
      bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
      bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 0;
      bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
      for (int i = 0; i < 16; i++) ws[i] = 4'hF;
      repeat (3) @(negedge aclk);
      #1;
      chk("rst_readies", {bus.arready, bus.awready, bus.wready}, 0);
      chk("rst_valids", {bus.rvalid, bus.bvalid, bus.rlast}, 0);
      chk("rst_ids", {bus.rid, bus.bid}, 0);
      chk("rst_resps", {bus.rresp, bus.bresp}, 0);
      chk("rst_rdata", bus.rdata, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      // both channels requested straight out of reset: read wins
      set_ar(32'h40, 0, 2, 1, 4'h1);
      set_aw(32'h40, 0, 2, 1, 4'h2);
      #1;
      chk("arb1_arready", bus.arready, 1);
      chk("arb1_awready", bus.awready, 0);
      wait_ar(t);
      read_data(1, 4'h1, 0, 0, 0, f, v);
      wait_aw(t);
      chk("aw_after_last_r", t, v + 1);
      wd[0] = 32'hA5A5_0001;
      write_data(1, 0, f, u);
      chk("w_first_ready", f, t + 1);
      b_resp(4'h2, 0, bt);
      chk("b_after_last_w", bt, u + 1);
      // prio alternates per grant, so read wins again
      set_ar(32'h40, 0, 2, 1, 4'h3);
      set_aw(32'h100, 3, 2, 1, 4'h5);
      #1;
      chk("arb2_arready", bus.arready, 1);
      chk("arb2_awready", bus.awready, 0);
      wait_ar(t);
      re[0] = 32'hA5A5_0001;
      read_data(1, 4'h3, 0, 0, 1, f, v);
      chk("r_first_valid", f, t + 2);
      wait_aw(t);
      for (int i = 0; i < 4; i++) wd[i] = i + 1;
      write_data(4, 3, f, u);
      b_resp(4'h5, 0, bt);
      set_ar(32'h100, 3, 2, 1, 4'h6);
      wait_ar(t);
      for (int i = 0; i < 4; i++) re[i] = i + 1;
      read_data(4, 4'h6, 0, 0, 1, f, v);
      set_aw(32'h0, 3, 2, 1, 4'h7);
      wait_aw(t);
      for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE_0000 + i;
      write_data(4, 3, f, u);
      b_resp(4'h7, 0, bt);
      // WRAP from 0x0C visits 0x0C, 0x00, 0x04, 0x08
      set_ar(32'h0C, 3, 2, 2, 4'h8);
      wait_ar(t);
      re[0] = 32'hC0DE_0003; re[1] = 32'hC0DE_0000; re[2] = 32'hC0DE_0001; re[3] = 32'hC0DE_0002;
      read_data(4, 4'h8, 0, 0, 1, f, v);
      set_ar(32'h104, 1, 2, 1, 4'h9);
      wait_ar(t);
      re[0] = 2; re[1] = 3;
      read_data(2, 4'h9, 0, 5, 1, f, v);
      set_aw(32'h100, 0, 2, 1, 4'hA);
      wait_aw(t);
      wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0010;
      write_data(1, 0, f, u);
      ws[0] = 4'hF;
      b_resp(4'hA, 0, bt);
      // reserved burst type reads data but flags SLVERR
      set_ar(32'h100, 0, 2, 3, 4'hB);
      wait_ar(t);
      re[0] = 32'h0000_FF01;
      read_data(1, 4'hB, 2'b10, 0, 1, f, v);
      set_aw(32'h300, 1, 2, 0, 4'hC);
      wait_aw(t);
      wd[0] = 32'h11; wd[1] = 32'h22;
      write_data(2, 1, f, u);
      b_resp(4'hC, 0, bt);
      set_ar(32'h300, 0, 2, 1, 4'hD);
      wait_ar(t);
      re[0] = 32'h22;
      read_data(1, 4'hD, 0, 0, 1, f, v);
      set_aw(32'h0001_0000, 0, 2, 1, 4'hE);
      wait_aw(t);
      wd[0] = 32'hDEAD_BEEF;
      write_data(1, 0, f, u);
      b_resp(4'hE, 2'b10, bt);
      set_ar(32'h0, 0, 2, 1, 4'h1);
      wait_ar(t);
      re[0] = 32'hC0DE_0000;
      read_data(1, 4'h1, 0, 0, 1, f, v);
      set_ar(32'h0001_0000, 0, 2, 1, 4'h2);
      wait_ar(t);
      re[0] = 32'h0;
      read_data(1, 4'h2, 2'b10, 0, 1, f, v);
      // wlast early on beat 1 of 4: all four beats still taken, SLVERR
      set_aw(32'h200, 3, 2, 1, 4'hF);
      wait_aw(t);
      for (int i = 0; i < 4; i++) wd[i] = 32'hA1 + i;
      write_data(4, 1, f, u);
      b_resp(4'hF, 2'b10, bt);
      set_ar(32'h200, 3, 2, 1, 4'h4);
      wait_ar(t);
      for (int i = 0; i < 4; i++) re[i] = 32'hA1 + i;
      read_data(4, 4'h4, 0, 0, 1, f, v);
      set_ar(32'h200, 3, 2, 1, 4'h6);
      wait_ar(t);
      @(negedge aclk);
      aresetn = 1'b0;
      @(negedge aclk);
      #1;
      chk("abort_rvalid", bus.rvalid, 0);
      chk("abort_rid", bus.rid, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      set_ar(32'h208, 0, 2, 1, 4'h7);
      wait_ar(t);
      re[0] = 32'hA3;
      read_data(1, 4'h7, 0, 0, 1, f, v);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
